// File: rtl/la_cmd_ctrl_pkg.sv
// Shared types and constants for the logic-analyzer command processor:
// opcodes, FSM states, register map, response codes and reset values.
package la_pkg;

    typedef enum logic [1:0] {
        RD      = 2'b00,
        WR      = 2'b01,
        DUMP    = 2'b10,
        ILLEGAL = 2'b11
    } opcode_t;

    typedef enum logic [2:0] {
        IDLE,
        RESP_WAIT,
        DUMP_RD,
        DUMP_SEND,
        DUMP_WAIT
    } state_t;

    localparam logic [5:0] TRIG_CFG     = 6'h00;
    localparam logic [5:0] CH1_TRIG_CFG = 6'h01;
    localparam logic [5:0] CH2_TRIG_CFG = 6'h02;
    localparam logic [5:0] CH3_TRIG_CFG = 6'h03;
    localparam logic [5:0] CH4_TRIG_CFG = 6'h04;
    localparam logic [5:0] CH5_TRIG_CFG = 6'h05;
    localparam logic [5:0] DECIMATOR    = 6'h06;
    localparam logic [5:0] VIH          = 6'h07;
    localparam logic [5:0] VIL          = 6'h08;
    localparam logic [5:0] MATCH_H      = 6'h09;
    localparam logic [5:0] MATCH_L      = 6'h0A;
    localparam logic [5:0] MASK_H       = 6'h0B;
    localparam logic [5:0] MASK_L       = 6'h0C;
    localparam logic [5:0] BAUD_CNT_H   = 6'h0D;
    localparam logic [5:0] BAUD_CNT_L   = 6'h0E;
    localparam logic [5:0] TRIG_POS_H   = 6'h0F;
    localparam logic [5:0] TRIG_POS_L   = 6'h10;

    localparam logic [7:0] ACK  = 8'hA5;
    localparam logic [7:0] NACK = 8'hEE;

    localparam logic [5:0]  TRIG_CFG_RST     = 6'h03;
    localparam logic [4:0]  CH_TRIG_CFG_RST  = 5'h01;
    localparam logic [3:0]  DECIMATOR_RST    = 4'h0;
    localparam logic [7:0]  VIH_RST          = 8'hAA;
    localparam logic [7:0]  VIL_RST          = 8'h55;
    localparam logic [15:0] MATCH_RST        = 16'h0000;
    localparam logic [15:0] MASK_RST         = 16'h0000;
    localparam logic [15:0] BAUD_CNT_RST     = 16'h01B2;
    localparam logic [15:0] TRIG_POS_RST     = 16'h0001;

    function automatic logic addr_legal(input logic [5:0] addr);
        return addr <= TRIG_POS_L;
    endfunction

    function automatic logic chan_legal(input logic [2:0] ch);
        return (ch >= 3'd1) && (ch <= 3'd5);
    endfunction

    // rdata packs {CH5..CH1}, CH1 in the low byte.
    function automatic logic [7:0] chan_byte(input logic [39:0] rdata, input logic [2:0] ch);
        logic [7:0] b;
        b = '0;
        case (ch)
            3'd1:    b = rdata[7:0];
            3'd2:    b = rdata[15:8];
            3'd3:    b = rdata[23:16];
            3'd4:    b = rdata[31:24];
            3'd5:    b = rdata[39:32];
            default: b = '0;
        endcase
        return b;
    endfunction

endpackage

// File: rtl/la_cmd_ctrl_if.sv
// Host command / response handshake between the UART wrapper and the
// command processor.
interface la_cmd_ctrl_if;
    logic [15:0] cmd;
    logic        cmd_rdy;
    logic        clr_cmd_rdy;
    logic [7:0]  resp;
    logic        send_resp;
    logic        resp_sent;

    modport master (
        output cmd, cmd_rdy, resp_sent,
        input  clr_cmd_rdy, resp, send_resp
    );

    modport slave (
        input  cmd, cmd_rdy, resp_sent,
        output clr_cmd_rdy, resp, send_resp
    );
endinterface

// File: rtl/la_cmd_ctrl_cfg_regs.sv
// Trigger/threshold configuration register file: write decode, read mux
// and the sticky capture_done bit in trig_cfg[5].
module la_cfg_regs
    import la_pkg::*;
(
    input  logic        clk,
    input  logic        rst,
    input  logic        wr_en,
    input  logic [5:0]  addr,
    input  logic [7:0]  wdata,
    input  logic        set_capture_done,
    output logic [7:0]  rd_data,
    output logic [5:0]  trig_cfg,
    output logic [4:0]  ch1_trig_cfg,
    output logic [4:0]  ch2_trig_cfg,
    output logic [4:0]  ch3_trig_cfg,
    output logic [4:0]  ch4_trig_cfg,
    output logic [4:0]  ch5_trig_cfg,
    output logic [3:0]  decimator,
    output logic [7:0]  vih,
    output logic [7:0]  vil,
    output logic [15:0] match,
    output logic [15:0] mask,
    output logic [15:0] baud_cnt,
    output logic [15:0] trig_pos
);

    always_ff @(posedge clk) begin
        if (rst) begin
            trig_cfg     <= TRIG_CFG_RST;
            ch1_trig_cfg <= CH_TRIG_CFG_RST;
            ch2_trig_cfg <= CH_TRIG_CFG_RST;
            ch3_trig_cfg <= CH_TRIG_CFG_RST;
            ch4_trig_cfg <= CH_TRIG_CFG_RST;
            ch5_trig_cfg <= CH_TRIG_CFG_RST;
            decimator    <= DECIMATOR_RST;
            vih          <= VIH_RST;
            vil          <= VIL_RST;
            match        <= MATCH_RST;
            mask         <= MASK_RST;
            baud_cnt     <= BAUD_CNT_RST;
            trig_pos     <= TRIG_POS_RST;
        end else begin
            if (wr_en) begin
                case (addr)
                    TRIG_CFG:     trig_cfg         <= wdata[5:0];
                    CH1_TRIG_CFG: ch1_trig_cfg     <= wdata[4:0];
                    CH2_TRIG_CFG: ch2_trig_cfg     <= wdata[4:0];
                    CH3_TRIG_CFG: ch3_trig_cfg     <= wdata[4:0];
                    CH4_TRIG_CFG: ch4_trig_cfg     <= wdata[4:0];
                    CH5_TRIG_CFG: ch5_trig_cfg     <= wdata[4:0];
                    DECIMATOR:    decimator        <= wdata[3:0];
                    VIH:          vih              <= wdata;
                    VIL:          vil              <= wdata;
                    MATCH_H:      match[15:8]      <= wdata;
                    MATCH_L:      match[7:0]       <= wdata;
                    MASK_H:       mask[15:8]       <= wdata;
                    MASK_L:       mask[7:0]        <= wdata;
                    BAUD_CNT_H:   baud_cnt[15:8]   <= wdata;
                    BAUD_CNT_L:   baud_cnt[7:0]    <= wdata;
                    TRIG_POS_H:   trig_pos[15:8]   <= wdata;
                    TRIG_POS_L:   trig_pos[7:0]    <= wdata;
                    default: ;
                endcase
            end
            // Placed after the write so a same-cycle set overrides bit 5.
            if (set_capture_done)
                trig_cfg[5] <= 1'b1;
        end
    end

    always_comb begin
        rd_data = '0;
        case (addr)
            TRIG_CFG:     rd_data = {2'b00, trig_cfg};
            CH1_TRIG_CFG: rd_data = {3'b000, ch1_trig_cfg};
            CH2_TRIG_CFG: rd_data = {3'b000, ch2_trig_cfg};
            CH3_TRIG_CFG: rd_data = {3'b000, ch3_trig_cfg};
            CH4_TRIG_CFG: rd_data = {3'b000, ch4_trig_cfg};
            CH5_TRIG_CFG: rd_data = {3'b000, ch5_trig_cfg};
            DECIMATOR:    rd_data = {4'h0, decimator};
            VIH:          rd_data = vih;
            VIL:          rd_data = vil;
            MATCH_H:      rd_data = match[15:8];
            MATCH_L:      rd_data = match[7:0];
            MASK_H:       rd_data = mask[15:8];
            MASK_L:       rd_data = mask[7:0];
            BAUD_CNT_H:   rd_data = baud_cnt[15:8];
            BAUD_CNT_L:   rd_data = baud_cnt[7:0];
            TRIG_POS_H:   rd_data = trig_pos[15:8];
            TRIG_POS_L:   rd_data = trig_pos[7:0];
            default:      rd_data = '0;
        endcase
    end

endmodule

// File: rtl/la_cmd_ctrl.sv
// Logic-analyzer command processor: decodes host read/write/dump commands,
// answers through the UART transmitter and streams capture RAM dumps.
module la_cmd_ctrl
    import la_pkg::*;
#(
    parameter int unsigned ENTRIES = 384,
    parameter int unsigned ADDR_W  = 9
) (
    input  logic              clk,
    input  logic              rst,
    la_cmd_ctrl_if.slave      bus,
    input  logic              set_capture_done,
    input  logic [ADDR_W-1:0] waddr,
    output logic [ADDR_W-1:0] raddr,
    input  logic [39:0]       rdata,
    output logic [5:0]        trig_cfg,
    output logic [4:0]        ch1_trig_cfg,
    output logic [4:0]        ch2_trig_cfg,
    output logic [4:0]        ch3_trig_cfg,
    output logic [4:0]        ch4_trig_cfg,
    output logic [4:0]        ch5_trig_cfg,
    output logic [3:0]        decimator,
    output logic [7:0]        vih,
    output logic [7:0]        vil,
    output logic [15:0]       match,
    output logic [15:0]       mask,
    output logic [15:0]       baud_cnt,
    output logic [15:0]       trig_pos
);

    localparam logic [ADDR_W-1:0] LAST = ADDR_W'(ENTRIES - 1);

    state_t            state, state_nxt;
    logic [7:0]        resp_q, resp_nxt;
    logic              send_q, send_nxt;
    logic              clr_q, clr_nxt;
    logic [ADDR_W-1:0] raddr_nxt;
    logic [ADDR_W-1:0] count, count_nxt;
    logic [2:0]        ch_sel, ch_nxt;
    logic              wr_en;
    logic [7:0]        rd_data;

    opcode_t    op;
    logic [5:0] addr;
    logic [7:0] data;

    assign op   = opcode_t'(bus.cmd[15:14]);
    assign addr = bus.cmd[13:8];
    assign data = bus.cmd[7:0];

    assign bus.resp        = resp_q;
    assign bus.send_resp   = send_q;
    assign bus.clr_cmd_rdy = clr_q;

    la_cfg_regs u_regs (
        .clk              (clk),
        .rst              (rst),
        .wr_en            (wr_en),
        .addr             (addr),
        .wdata            (data),
        .set_capture_done (set_capture_done),
        .rd_data          (rd_data),
        .trig_cfg         (trig_cfg),
        .ch1_trig_cfg     (ch1_trig_cfg),
        .ch2_trig_cfg     (ch2_trig_cfg),
        .ch3_trig_cfg     (ch3_trig_cfg),
        .ch4_trig_cfg     (ch4_trig_cfg),
        .ch5_trig_cfg     (ch5_trig_cfg),
        .decimator        (decimator),
        .vih              (vih),
        .vil              (vil),
        .match            (match),
        .mask             (mask),
        .baud_cnt         (baud_cnt),
        .trig_pos         (trig_pos)
    );

    always_ff @(posedge clk) begin
        if (rst) begin
            state  <= IDLE;
            resp_q <= '0;
            send_q <= 1'b0;
            clr_q  <= 1'b0;
            raddr  <= '0;
            count  <= '0;
            ch_sel <= '0;
        end else begin
            state  <= state_nxt;
            resp_q <= resp_nxt;
            send_q <= send_nxt;
            clr_q  <= clr_nxt;
            raddr  <= raddr_nxt;
            count  <= count_nxt;
            ch_sel <= ch_nxt;
        end
    end

    always_comb begin
        state_nxt = state;
        resp_nxt  = resp_q;
        send_nxt  = 1'b0;
        clr_nxt   = 1'b0;
        raddr_nxt = raddr;
        count_nxt = count;
        ch_nxt    = ch_sel;
        wr_en     = 1'b0;
        case (state)
            IDLE: begin
                if (bus.cmd_rdy) begin
                    clr_nxt   = 1'b1;
                    send_nxt  = 1'b1;
                    resp_nxt  = NACK;
                    state_nxt = RESP_WAIT;
                    case (op)
                        WR: if (addr_legal(addr)) begin
                            wr_en    = 1'b1;
                            resp_nxt = ACK;
                        end
                        RD: if (addr_legal(addr))
                            resp_nxt = rd_data;
                        // Dump starts at the write pointer, which is the oldest sample.
                        DUMP: if (chan_legal(data[2:0])) begin
                            send_nxt  = 1'b0;
                            raddr_nxt = waddr;
                            count_nxt = '0;
                            ch_nxt    = data[2:0];
                            state_nxt = DUMP_RD;
                        end
                        default: ;
                    endcase
                end
            end
            RESP_WAIT: begin
                if (bus.resp_sent)
                    state_nxt = IDLE;
            end
            DUMP_RD: begin
                state_nxt = DUMP_SEND;
            end
            DUMP_SEND: begin
                resp_nxt  = chan_byte(rdata, ch_sel);
                send_nxt  = 1'b1;
                state_nxt = DUMP_WAIT;
            end
            DUMP_WAIT: begin
                if (bus.resp_sent) begin
                    if (count == LAST) begin
                        state_nxt = IDLE;
                    end else begin
                        count_nxt = count + 1'b1;
                        raddr_nxt = (raddr == LAST) ? '0 : raddr + 1'b1;
                        state_nxt = DUMP_RD;
                    end
                end
            end
            default: state_nxt = IDLE;
        endcase
    end

endmodule

// File: tb/tb_la_cmd_ctrl.sv
// Scoreboard bench for la_cmd_ctrl: a byte-level register/RAM model predicts
// every response; a monitor pops and compares on each send_resp.
module tb_la_cmd_ctrl;
    import la_pkg::*;

    localparam int ENTRIES = 384;
    localparam int ADDR_W  = 9;

    logic clk = 1'b0;
    logic rst;
    logic set_capture_done;
    logic [ADDR_W-1:0] waddr, raddr;
    logic [39:0] rdata;
    logic [5:0]  trig_cfg;
    logic [4:0]  ch1_trig_cfg, ch2_trig_cfg, ch3_trig_cfg, ch4_trig_cfg, ch5_trig_cfg;
    logic [3:0]  decimator;
    logic [7:0]  vih, vil;
    logic [15:0] match, mask, baud_cnt, trig_pos;

    la_cmd_ctrl_if bus();

    la_cmd_ctrl #(.ENTRIES(ENTRIES), .ADDR_W(ADDR_W)) dut (
        .clk(clk), .rst(rst), .bus(bus),
        .set_capture_done(set_capture_done), .waddr(waddr), .raddr(raddr), .rdata(rdata),
        .trig_cfg(trig_cfg), .ch1_trig_cfg(ch1_trig_cfg), .ch2_trig_cfg(ch2_trig_cfg),
        .ch3_trig_cfg(ch3_trig_cfg), .ch4_trig_cfg(ch4_trig_cfg), .ch5_trig_cfg(ch5_trig_cfg),
        .decimator(decimator), .vih(vih), .vil(vil), .match(match), .mask(mask),
        .baud_cnt(baud_cnt), .trig_pos(trig_pos)
    );

    always #5 clk = ~clk;

    int n_cmp = 0;
    int n_bad = 0;
    logic [7:0]  exp_q[$];
    int unsigned exp_total = 0;
    int unsigned sent_cnt = 0;
    int unsigned resp_seen = 0;
    int unsigned stray_req = 0;
    int unsigned stray_done = 0;
    bit uart_hold = 1'b0;
    logic [7:0]  mreg[17];
    logic [39:0] ram[ENTRIES];

    always @(posedge clk) rdata <= ram[raddr];

    task automatic chk(input string name, input logic [127:0] act, input logic [127:0] exp);
        n_cmp++;
        if (act !== exp) begin
            n_bad++;
            $display("FAIL %s: got %0h expected %0h", name, act, exp);
        end
    endtask

    function automatic logic [7:0] reg_mask(input int a);
        if (a == 0) return 8'h3F;
        if (a <= 5) return 8'h1F;
        if (a == 6) return 8'h0F;
        return 8'hFF;
    endfunction

    function automatic void model_reset();
        mreg[0] = 8'h03;
        for (int i = 1; i <= 5; i++) mreg[i] = 8'h01;
        mreg[6] = 8'h00; mreg[7] = 8'hAA; mreg[8] = 8'h55;
        for (int i = 9; i <= 12; i++) mreg[i] = 8'h00;
        mreg[13] = 8'h01; mreg[14] = 8'hB2; mreg[15] = 8'h00; mreg[16] = 8'h01;
    endfunction

    // Predicts the response bytes of one command and applies its register effect.
    function automatic void model_cmd(input logic [1:0] op, input logic [5:0] a,
                                      input logic [7:0] d, input bit scd);
        int ch;
        logic [39:0] w;
        ch = int'(d[2:0]);
        if (op == 2'b00) begin
            if (a <= 6'd16) exp_q.push_back(mreg[a]); else exp_q.push_back(8'hEE);
            exp_total++;
        end else if (op == 2'b01) begin
            if (a <= 6'd16) begin
                mreg[a] = d & reg_mask(int'(a));
                exp_q.push_back(8'hA5);
            end else begin
                exp_q.push_back(8'hEE);
            end
            exp_total++;
        end else if (op == 2'b10 && ch >= 1 && ch <= 5) begin
            for (int i = 0; i < ENTRIES; i++) begin
                w = ram[(int'(waddr) + i) % ENTRIES];
                exp_q.push_back(w[8*ch-8 +: 8]);
            end
            exp_total += ENTRIES;
        end else begin
            exp_q.push_back(8'hEE);
            exp_total++;
        end
        if (scd) mreg[0] = mreg[0] | 8'h20;
    endfunction

    task automatic check_outputs(input string name);
        logic [127:0] act, exp;
        act = {trig_cfg, ch1_trig_cfg, ch2_trig_cfg, ch3_trig_cfg, ch4_trig_cfg, ch5_trig_cfg,
               decimator, vih, vil, match, mask, baud_cnt, trig_pos};
        exp = {mreg[0][5:0], mreg[1][4:0], mreg[2][4:0], mreg[3][4:0], mreg[4][4:0],
               mreg[5][4:0], mreg[6][3:0], mreg[7], mreg[8], mreg[9], mreg[10], mreg[11],
               mreg[12], mreg[13], mreg[14], mreg[15], mreg[16]};
        chk(name, act, exp);
    endtask

    task automatic issue(input logic [1:0] op, input logic [5:0] a, input logic [7:0] d,
                         input bit scd);
        int unsigned t;
        @(negedge clk);
        bus.cmd = {op, a, d};
        bus.cmd_rdy = 1'b1;
        set_capture_done = scd;
        model_cmd(op, a, d, scd);
        @(negedge clk);
        set_capture_done = 1'b0;
        t = 0;
        while (!bus.clr_cmd_rdy && t < 50) begin @(negedge clk); t++; end
        chk("accept", 128'(bus.clr_cmd_rdy), 128'(1));
        bus.cmd_rdy = 1'b0;
    endtask

    task automatic wait_done(input int unsigned bound);
        int unsigned t;
        t = 0;
        while (sent_cnt != exp_total && t < bound) begin @(negedge clk); t++; end
        chk("done_in_time", 128'(sent_cnt), 128'(exp_total));
    endtask

    // Monitor: every send_resp pulse must match the oldest predicted byte.
    initial begin
        forever begin
            @(negedge clk);
            if (!rst && bus.send_resp) begin
                resp_seen++;
                if (exp_q.size() == 0) begin
                    n_cmp++;
                    n_bad++;
                    $display("FAIL unexpected_resp: got %0h expected none", bus.resp);
                end else begin
                    chk("resp", 128'(bus.resp), 128'(exp_q.pop_front()));
                end
            end
        end
    end

    // UART transmitter model, plus injection of stray resp_sent pulses.
    initial begin
        bus.resp_sent = 1'b0;
        forever begin
            @(negedge clk);
            if (bus.send_resp && !uart_hold && !rst) begin
                repeat ($urandom_range(1, 4)) @(posedge clk);
                #1 bus.resp_sent = 1'b1;
                @(posedge clk);
                #1 bus.resp_sent = 1'b0;
                sent_cnt++;
            end else if (stray_req != stray_done) begin
                @(posedge clk);
                #1 bus.resp_sent = 1'b1;
                @(posedge clk);
                #1 bus.resp_sent = 1'b0;
                stray_done++;
            end
        end
    end

    initial begin
        #2000000;
        $display("FAIL watchdog: got timeout expected completion");
        $fatal(1, "watchdog expired");
    end

    initial begin
        int unsigned base, t;
        rst = 1'b1;
        bus.cmd = '0;
        bus.cmd_rdy = 1'b0;
        set_capture_done = 1'b0;
        waddr = '0;
        for (int i = 0; i < ENTRIES; i++) begin
            ram[i] = {8'($urandom), 32'($urandom)};
            ram[i][15:8] = 8'(i);
        end
        model_reset();
        repeat (3) @(negedge clk);
        check_outputs("reset_regs");
        chk("reset_hs", {bus.resp, bus.send_resp, bus.clr_cmd_rdy, raddr}, '0);
        chk("reset_state", 128'(dut.state), 128'(IDLE));
        rst = 1'b0;

        issue(2'b00, 6'h07, 8'h00, 0); wait_done(100);
        issue(2'b00, 6'h08, 8'h00, 0); wait_done(100);
        issue(2'b00, 6'h00, 8'h00, 0); wait_done(100);

        issue(2'b01, 6'h0F, 8'h7F, 0); wait_done(100);
        issue(2'b01, 6'h10, 8'hFF, 0); wait_done(100);
        chk("trig_pos", 128'(trig_pos), 128'(16'h7FFF));
        issue(2'b00, 6'h0F, 8'h00, 0); wait_done(100);
        issue(2'b00, 6'h10, 8'h00, 0); wait_done(100);

        issue(2'b11, 6'h07, 8'h46, 0); wait_done(100);
        check_outputs("illegal_op_regs");
        issue(2'b01, 6'h11, 8'h12, 0); wait_done(100);
        check_outputs("bad_addr_regs");

        issue(2'b01, 6'h01, 8'h1F, 0); wait_done(100);
        chk("ch1_trig_cfg", 128'(ch1_trig_cfg), 128'(5'h1F));
        issue(2'b00, 6'h01, 8'h00, 0); wait_done(100);
        issue(2'b01, 6'h00, 8'h16, 1); wait_done(100);
        chk("trig_cfg_set_wins", 128'(trig_cfg), 128'(6'h36));

        for (int k = 0; k < 40; k++) begin
            logic [1:0] op;
            logic [5:0] a;
            logic [7:0] d;
            op = 2'($urandom_range(0, 3));
            a  = 6'($urandom_range(0, 19));
            d  = 8'($urandom);
            if (op == 2'b10) d[2:0] = ($urandom_range(0, 1) == 0) ? 3'd0 : 3'(6 + $urandom_range(0, 1));
            issue(op, a, d, 0);
            wait_done(100);
        end
        check_outputs("random_regs");

        issue(2'b01, 6'h00, 8'h05, 0); wait_done(100);
        @(negedge clk); set_capture_done = 1'b1;
        @(negedge clk); set_capture_done = 1'b0;
        mreg[0] = mreg[0] | 8'h20;
        chk("capture_done_set", 128'(trig_cfg), 128'(mreg[0][5:0]));

        waddr = 9'd380;
        base = resp_seen;
        issue(2'b10, 6'h00, 8'h02, 0); wait_done(20000);
        chk("dump_len", 128'(resp_seen - base), 128'(ENTRIES));
        stray_req++;
        repeat (10) @(negedge clk);
        chk("stray_sent_ignored", 128'(resp_seen - base), 128'(ENTRIES));
        chk("idle_after_dump", 128'(dut.state), 128'(IDLE));

        waddr = 9'd0;
        issue(2'b10, 6'h00, 8'h05, 0); wait_done(20000);
        issue(2'b10, 6'h00, 8'h06, 0); wait_done(100);

        uart_hold = 1'b1;
        waddr = 9'd5;
        base = resp_seen;
        @(negedge clk);
        bus.cmd = {2'b10, 6'h00, 8'h03};
        bus.cmd_rdy = 1'b1;
        exp_q.push_back(ram[5][23:16]);
        @(negedge clk);
        bus.cmd_rdy = 1'b0;
        t = 0;
        while (resp_seen == base && t < 50) begin @(negedge clk); t++; end
        chk("dump_first_byte", 128'(resp_seen), 128'(base + 1));
        @(negedge clk);
        rst = 1'b1;
        @(negedge clk);
        model_reset();
        chk("rst_state", 128'(dut.state), 128'(IDLE));
        chk("rst_hs", {bus.resp, bus.send_resp, bus.clr_cmd_rdy, raddr}, '0);
        check_outputs("rst_regs");
        rst = 1'b0;
        repeat (20) @(negedge clk);
        chk("no_resp_after_rst", 128'(resp_seen), 128'(base + 1));
        uart_hold = 1'b0;
        issue(2'b00, 6'h07, 8'h00, 0); wait_done(100);

        repeat (5) @(negedge clk);
        chk("queue_drained", 128'(exp_q.size()), 128'(0));
        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
        $finish;
    end

endmodule

// File: doc/la_cmd_ctrl.md
Name: la_cmd_ctrl

Overview:
Command processor of the logic-analyzer digital core. Accepts 16-bit host commands assembled by the UART wrapper, decodes read, write and dump opcodes, and holds the trigger/threshold configuration register file that drives the trigger, PWM and capture logic. Sends one-byte responses back through the UART transmitter. For dumps, sequences the circular capture RAM and streams one channel's samples to the host, oldest first.

Parameters:
ENTRIES, 384, capture RAM depth in samples
ADDR_W, 9, capture RAM address width

Ports:
clk  in  1  system clock (100MHz)
rst  in  1  synchronous active-high reset
cmd  in  16  command word {op[15:14], addr[13:8], data[7:0]}
cmd_rdy  in  1  cmd valid; held until clr_cmd_rdy
clr_cmd_rdy  out  1  one-cycle pulse when cmd is accepted
resp  out  8  response byte
send_resp  out  1  one-cycle pulse to start transmission of resp
resp_sent  in  1  one-cycle pulse when the UART transmitter finishes
set_capture_done  in  1  pulse from the capture unit
waddr  in  ADDR_W  capture write pointer (next write location)
raddr  out  ADDR_W  capture RAM read address
rdata  in  8x5  {CH5..CH1} sample bytes; valid 1 cycle after raddr
trig_cfg  out  6  reg 0x00
ch1_trig_cfg..ch5_trig_cfg  out  5 each  regs 0x01..0x05
decimator  out  4  reg 0x06
vih  out  8  reg 0x07
vil  out  8  reg 0x08
match  out  16  regs 0x09 (H), 0x0A (L)
mask  out  16  regs 0x0B (H), 0x0C (L)
baud_cnt  out  16  regs 0x0D (H), 0x0E (L)
trig_pos  out  16  regs 0x0F (H), 0x10 (L)

Behaviour:
- Opcodes: 00 = read, 01 = write, 10 = dump, 11 = illegal.
- Reset values:
  - trig_cfg 0x03; chN_trig_cfg 0x01; decimator 0; vih 0xAA; vil 0x55.
  - match 0; mask 0; baud_cnt 0x01B2; trig_pos 0x0001.
  - resp 0; send_resp 0; clr_cmd_rdy 0; raddr 0; state IDLE.
- FSM states: IDLE, RESP_WAIT, DUMP_RD, DUMP_SEND, DUMP_WAIT.
- IDLE, cmd_rdy=1:
  - Pulse clr_cmd_rdy and decode in the same cycle.
  - Write to a legal addr: register updates on that edge; next cycle resp=0xA5, send_resp pulse, then RESP_WAIT.
  - Read: resp = register value, zero-extended; send_resp pulse next cycle; then RESP_WAIT.
  - Illegal op, or addr > 0x10: resp=0xEE; no register change; then RESP_WAIT.
  - Dump: data[2:0] must be 1..5, otherwise respond 0xEE. If legal, raddr=waddr (oldest sample), count=0, go to DUMP_RD.
- RESP_WAIT: stay until resp_sent, then IDLE. No new cmd is accepted while busy; cmd_rdy simply stays high.
- DUMP_RD: one cycle for RAM latency, then DUMP_SEND.
- DUMP_SEND: resp = selected channel byte of rdata; send_resp pulse; go to DUMP_WAIT.
- DUMP_WAIT, on resp_sent:
  - count==ENTRIES-1: go to IDLE.
  - Otherwise: count+1; raddr = (raddr==ENTRIES-1) ? 0 : raddr+1; go to DUMP_RD.
- Dump sends exactly ENTRIES bytes. There is no A5 after a dump.
- trig_cfg[5] is capture_done:
  - set_capture_done sets it.
  - A host write to 0x00 loads all 6 bits.
  - Same-cycle write and set: the written value is ORed with bit5=1 (set wins).
- Write data wider than a register is truncated to its LSBs.
- rst asserted in any state: return to IDLE with reset values next edge. A pending send_resp is dropped.

Decomposition:
- Package la_pkg:
  - opcode enum (RD, WR, DUMP, ILLEGAL).
  - register address localparams (TRIG_CFG=6'h00 .. TRIG_POS_L=6'h10).
  - ACK=8'hA5, NACK=8'hEE.
  - reset-value constants.
  - state enum.
- One sub-module, la_cfg_regs: register file with write decode, read mux and the capture_done set logic. The FSM and dump sequencing remain in la_cmd_ctrl.

Test Plan:
- Reset, then read 0x07 -> resp 0xAA; read 0x08 -> 0x55; read 0x00 -> 0x03.
- Write 0x0F=0x7F, then 0x10=0xFF -> two 0xA5 responses; trig_pos=0x7FFF; reads return 0x7F, 0xFF.
- Cmd 0xC746 (op 11) -> 0xEE, all registers unchanged. Write addr 0x11 -> 0xEE.
- Write 0x01=0x1F -> ch1_trig_cfg=5'h1F; readback 0x1F. Write 0x00=0x16 in the same cycle as set_capture_done -> trig_cfg=0x36.
- Preload RAM CH2[i]=i[7:0], waddr=380, dump CH2 -> 384 bytes, first 0x7C (380), wrapping 383->0, last 0x7B (379). The 385th resp_sent is ignored; the FSM is back in IDLE.
- Assert rst during DUMP_WAIT -> next cycle state IDLE, registers at reset values, no further send_resp.
